// File: rtl/hazard_scheduler_if.sv
// Decode-side interlock bundle: instruction fields in,
// stall/bubble controls and debug statistics out.
interface hazard_scheduler_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 i_valid;
  logic [7:0]           i_opcode;
  logic [3:0]           i_rs1;
  logic [3:0]           i_rs2;
  logic [3:0]           i_rd;
  logic                 i_flush;
  logic                 o_stall;
  logic                 o_bubble;
  logic                 o_busy;
  logic [CNT_WIDTH-1:0] o_stall_cycles;
  logic [CNT_WIDTH-1:0] o_hazard_events;

  modport master (
    output i_valid, i_opcode, i_rs1, i_rs2, i_rd, i_flush,
    input  o_stall, o_bubble, o_busy,
    input  o_stall_cycles, o_hazard_events
  );

  modport slave (
    input  i_valid, i_opcode, i_rs1, i_rs2, i_rd, i_flush,
    output o_stall, o_bubble, o_busy,
    output o_stall_cycles, o_hazard_events
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Scoreboard interlock beside decode: stalls on RAW hazards
// against in-flight destinations and counts stall statistics.
module hazard_scheduler #(
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  hazard_scheduler_if.slave bus
);
  localparam logic [7:0] OP_LDA = 8'd1;
  localparam logic [7:0] OP_STA = 8'd2;
  localparam logic [7:0] OP_ADD = 8'd3;
  localparam logic [7:0] OP_SUB = 8'd4;
  localparam int NCMP = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  logic [DEPTH-1:0]      slot_valid;
  logic [DEPTH-1:0][3:0] slot_rd;
  logic                  reads1;
  logic                  reads2;
  logic                  writes;
  logic                  hit1;
  logic                  hit2;
  logic                  hazard;
  logic                  prev_stall;
  logic [CNT_WIDTH-1:0]  stall_cycles;
  logic [CNT_WIDTH-1:0]  hazard_events;

  // Classify which sources the opcode reads and whether it writes rd
  always_comb begin
    reads1 = 1'b0;
    reads2 = 1'b0;
    writes = 1'b0;
    unique case (1'b1)
      (bus.i_opcode == OP_ADD) || (bus.i_opcode == OP_SUB): begin
        reads1 = 1'b1;
        reads2 = 1'b1;
        writes = 1'b1;
      end
      bus.i_opcode == OP_STA: reads1 = 1'b1;
      bus.i_opcode == OP_LDA: writes = 1'b1;
      default: ;
    endcase
  end

  // Match sources against slots not yet visible in the regfile
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = 0; k < NCMP; k++) begin
      if (slot_valid[k] && slot_rd[k] == bus.i_rs1)
        hit1 = 1'b1;
      if (slot_valid[k] && slot_rd[k] == bus.i_rs2)
        hit2 = 1'b1;
    end
    hazard = bus.i_valid &&
             ((reads1 && hit1) || (reads2 && hit2));
  end

  assign bus.o_stall         = hazard;
  assign bus.o_bubble        = hazard;
  assign bus.o_busy          = |slot_valid;
  assign bus.o_stall_cycles  = stall_cycles;
  assign bus.o_hazard_events = hazard_events;

  // Advance the scoreboard; a stalled decode enters as a bubble
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slot_valid <= '0;
      slot_rd    <= '0;
    end else if (bus.i_flush) begin
      slot_valid <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_rd[k]    <= slot_rd[k-1];
      end
      slot_valid[0] <= bus.i_valid && writes && !hazard;
      slot_rd[0]    <= bus.i_rd;
    end
  end

  // Saturating stall statistics, unaffected by flush
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prev_stall    <= 1'b0;
      stall_cycles  <= '0;
      hazard_events <= '0;
    end else begin
      prev_stall <= hazard;
      if (hazard && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (hazard && !prev_stall && !(&hazard_events))
        hazard_events <= hazard_events + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench: cycle table on the default build, plus
// bypass, saturation and async-reset sequences.
module tb_hazard_scheduler;
  logic clk;
  logic rst;
  logic rst2;
  int   checks;
  int   errors;

  hazard_scheduler_if #(.CNT_WIDTH(16)) b0 ();
  hazard_scheduler_if #(.CNT_WIDTH(16)) b1 ();
  hazard_scheduler_if #(.CNT_WIDTH(4))  b2 ();

  hazard_scheduler #(.DEPTH(3), .WB_BYPASS(0), .CNT_WIDTH(16))
    u0 (.i_clk(clk), .i_reset(rst), .bus(b0));
  hazard_scheduler #(.DEPTH(3), .WB_BYPASS(1), .CNT_WIDTH(16))
    u1 (.i_clk(clk), .i_reset(rst), .bus(b1));
  hazard_scheduler #(.DEPTH(3), .WB_BYPASS(0), .CNT_WIDTH(4))
    u2 (.i_clk(clk), .i_reset(rst2), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] op;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic       fl;
    logic       st;
    logic       bz;
    int         cyc;
    int         ev;
  } vec_t;

  vec_t tbl [33];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive0(input vec_t t);
    b0.i_valid  = t.v;
    b0.i_opcode = t.op;
    b0.i_rs1    = t.rs1;
    b0.i_rs2    = t.rs2;
    b0.i_rd     = t.rd;
    b0.i_flush  = t.fl;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    // v op rs1 rs2 rd fl | stall busy cycles events
    tbl[0]  = '{1, 3, 2, 3, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 3, 1, 5, 4, 0, 1, 1, 0, 0};
    tbl[2]  = '{1, 3, 1, 5, 4, 0, 1, 1, 1, 1};
    tbl[3]  = '{1, 3, 1, 5, 4, 0, 1, 1, 2, 1};
    tbl[4]  = '{1, 3, 1, 5, 4, 0, 0, 0, 3, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 1, 3, 1};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 1, 3, 1};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 0, 1, 3, 1};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 3, 1};
    tbl[9]  = '{1, 1, 0, 0, 7, 0, 0, 0, 3, 1};
    tbl[10] = '{1, 2, 7, 0, 0, 0, 1, 1, 3, 1};
    tbl[11] = '{1, 2, 7, 0, 0, 0, 1, 1, 4, 2};
    tbl[12] = '{1, 2, 7, 0, 0, 0, 1, 1, 5, 2};
    tbl[13] = '{1, 2, 7, 0, 0, 0, 0, 0, 6, 2};
    tbl[14] = '{1, 3, 2, 3, 1, 0, 0, 0, 6, 2};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 6, 2};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 6, 2};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 6, 2};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 6, 2};
    tbl[19] = '{1, 3, 8, 9, 1, 0, 0, 0, 6, 2};
    tbl[20] = '{1, 3, 10, 11, 2, 0, 0, 1, 6, 2};
    tbl[21] = '{1, 4, 12, 13, 3, 0, 0, 1, 6, 2};
    tbl[22] = '{1, 2, 9, 3, 5, 0, 0, 1, 6, 2};
    tbl[23] = '{1, 1, 3, 2, 12, 0, 0, 1, 6, 2};
    tbl[24] = '{1, 9, 12, 12, 6, 0, 0, 1, 6, 2};
    tbl[25] = '{0, 3, 12, 12, 0, 0, 0, 1, 6, 2};
    tbl[26] = '{0, 0, 0, 0, 0, 0, 0, 1, 6, 2};
    tbl[27] = '{0, 0, 0, 0, 0, 0, 0, 0, 6, 2};
    tbl[28] = '{1, 3, 8, 9, 0, 0, 0, 0, 6, 2};
    tbl[29] = '{1, 0, 0, 0, 0, 0, 0, 1, 6, 2};
    tbl[30] = '{1, 3, 0, 0, 4, 1, 1, 1, 6, 2};
    tbl[31] = '{1, 3, 0, 0, 4, 0, 0, 0, 7, 3};
    tbl[32] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 3};

    rst  = 1'b1;
    rst2 = 1'b1;
    drive0(tbl[26]);
    b1.i_valid = 0; b1.i_opcode = 0; b1.i_rs1 = 0;
    b1.i_rs2 = 0; b1.i_rd = 0; b1.i_flush = 0;
    b2.i_valid = 0; b2.i_opcode = 0; b2.i_rs1 = 0;
    b2.i_rs2 = 0; b2.i_rd = 0; b2.i_flush = 0;
    #1;
    chk("rst_stall", int'(b0.o_stall), 0);
    chk("rst_bubble", int'(b0.o_bubble), 0);
    chk("rst_busy", int'(b0.o_busy), 0);
    chk("rst_cycles", int'(b0.o_stall_cycles), 0);
    chk("rst_events", int'(b0.o_hazard_events), 0);
    @(negedge clk);
    rst  = 1'b0;
    rst2 = 1'b0;

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      drive0(tbl[i]);
      #1;
      chk($sformatf("row%0d_stall", i), int'(b0.o_stall), int'(tbl[i].st));
      chk($sformatf("row%0d_bubble", i), int'(b0.o_bubble), int'(tbl[i].st));
      chk($sformatf("row%0d_busy", i), int'(b0.o_busy), int'(tbl[i].bz));
      chk($sformatf("row%0d_cycles", i), int'(b0.o_stall_cycles), tbl[i].cyc);
      chk($sformatf("row%0d_events", i), int'(b0.o_hazard_events), tbl[i].ev);
    end

    @(negedge clk);
    b1.i_valid = 1; b1.i_opcode = 3;
    b1.i_rs1 = 2; b1.i_rs2 = 3; b1.i_rd = 1;
    #1;
    chk("byp_first_stall", int'(b1.o_stall), 0);
    @(negedge clk);
    b1.i_rs1 = 1; b1.i_rs2 = 5; b1.i_rd = 4;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!b1.o_stall) break;
      n++;
      @(negedge clk);
    end
    chk("byp_stall_len", n, 2);
    chk("byp_cycles", int'(b1.o_stall_cycles), 2);
    chk("byp_events", int'(b1.o_hazard_events), 1);
    b1.i_valid = 0;

    @(negedge clk);
    b2.i_valid = 1; b2.i_opcode = 3;
    b2.i_rs1 = 1; b2.i_rs2 = 1; b2.i_rd = 1;
    repeat (28) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sat_cycles", int'(b2.o_stall_cycles), 15);
    chk("sat_events", int'(b2.o_hazard_events), 7);
    chk("sat_issue_stall", int'(b2.o_stall), 0);
    @(negedge clk);
    #1;
    chk("sat_mid_stall", int'(b2.o_stall), 1);
    chk("sat_hold", int'(b2.o_stall_cycles), 15);
    rst2 = 1'b1;
    #1;
    chk("arst_stall", int'(b2.o_stall), 0);
    chk("arst_busy", int'(b2.o_busy), 0);
    chk("arst_cycles", int'(b2.o_stall_cycles), 0);
    chk("arst_events", int'(b2.o_hazard_events), 0);
    @(negedge clk);
    rst2 = 1'b0;
    b2.i_valid = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
